// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with per-register busy scoreboard
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  set_en,
  input  logic [AW-1:0]         set_addr,
  output logic [NREG-1:0]       busy_vec
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;

  // Ascending port order makes the highest-index port the last (winning) assignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && waddr[k*AW +: AW] != '0)
          regs[waddr[k*AW +: AW]] <= wdata[k*DATA_W +: DATA_W];
      end
      busy <= busy_next;
    end
  end

  // Retiring writes clear first so a same-cycle issue to that register leaves it busy.
  always_comb begin
    busy_next = busy;
    for (int k = 0; k < NWR; k++) begin
      if (we[k]) busy_next[waddr[k*AW +: AW]] = 1'b0;
    end
    if (set_en) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] val;
    logic              hit;
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    val   = '0;
    hit   = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      ra  = raddr[j*AW +: AW];
      val = '0;
      hit = 1'b0;
      if (!rst && re[j] && ra != '0) begin
        val = regs[ra];
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && waddr[k*AW +: AW] == ra) begin
            hit = 1'b1;
            val = wdata[k*DATA_W +: DATA_W];
          end
        end
        rdata[j*DATA_W +: DATA_W] = val;
        rbusy[j]                  = busy[ra] & ~hit;
      end
    end
  end

  assign busy_vec = busy;

endmodule
